// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_pkg
//  Description : Shared character and timing constants for the rs232 blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;

endpackage
`default_nettype wire

// File: rtl/rs232_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_fifo_mem
//  Description : 2**ADDR_W x 8 storage, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_fifo_mem
  import rs232_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  // Contents are deliberately left unreset; occupancy is tracked by the owner.
  logic [7:0] r_mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_rx_fifo
//  Description : FWFT receive byte buffer with overflow flag and line counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx_fifo
  import rs232_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] TERM       = CHAR_CR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_vld,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [DEPTH_LOG2:0] lines,
  output logic                line_avail
);

  localparam int unsigned               c_DEPTH   = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]       c_FULL    = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2:0]       c_CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0]     c_PTR_ONE = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   r_lines;
  logic                  r_overflow;

  logic [7:0] w_head;
  logic       w_valid;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;
  logic       w_drop;
  logic       w_wr_term;
  logic       w_pop_term;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == c_FULL);
  assign w_pop      = w_valid & out_ready;
  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign w_wr       = rx_vld & (~w_full | w_pop);
  assign w_drop     = rx_vld & w_full & ~w_pop;
  assign w_wr_term  = w_wr & (rx_data == TERM);
  assign w_pop_term = w_pop & (w_head == TERM);

  rs232_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clock   (clock),
    .wr_en   (w_wr),
    .wr_addr (r_wr_ptr),
    .wr_data (rx_data),
    .rd_addr (r_rd_ptr),
    .rd_data (w_head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lines    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      if (w_wr && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - c_CNT_ONE;
      end

      if (w_wr_term && !w_pop_term) begin
        r_lines <= r_lines + c_CNT_ONE;
      end else if (!w_wr_term && w_pop_term) begin
        r_lines <= r_lines - c_CNT_ONE;
      end

      // A fresh drop outranks a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid  = w_valid;
  assign out_data   = w_valid ? w_head : 8'h00;
  assign count      = r_count;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign lines      = r_lines;
  assign line_avail = (r_lines != '0);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_rx_fifo
//  Description : Scoreboard bench for the receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx_fifo;

  localparam int         DL    = 4;
  localparam int         DEPTH = 16;
  localparam logic [7:0] TERM  = 8'h0D;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_vld = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DL:0]   count;
  logic          full;
  logic          overflow;
  logic          clr_ovf = 1'b0;
  logic [DL:0]   lines;
  logic          line_avail;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  bit         m_ovf = 1'b0;

  rs232_rx_fifo #(.DEPTH_LOG2(DL), .TERM(TERM)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .lines      (lines),
    .line_avail (line_avail)
  );

  always #5 clock = ~clock;

  function automatic int m_lines();
    int n = 0;
    foreach (sb[i]) if (sb[i] == TERM) n++;
    return n;
  endfunction

  // Drive one clock cycle of stimulus and advance the reference model.
  task automatic cycle(input bit vld, input logic [7:0] d, input bit rdy, input bit clr);
    bit pop;
    bit was_full;
    logic [7:0] tmp;
    rx_vld = vld; rx_data = d; out_ready = rdy; clr_ovf = clr;
    pop = rdy && (sb.size() > 0);
    was_full = (sb.size() == DEPTH);
    if (pop) tmp = sb.pop_front();
    if (vld && (!was_full || pop)) sb.push_back(d);
    if (vld && was_full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clock); #1;
    rx_vld = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (count !== 0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (lines !== 0) begin bad++; $display("FAIL reset_lines: got %0d want 0", lines); end
    total++; if ({full, out_valid, line_avail, overflow} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {full, out_valid, line_avail, overflow}); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    @(posedge clock); #1; reset = 1'b0;
    cycle(0, 8'h00, 1, 0);
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL idle_empty: got v=%b d=%h want v=0 d=00", out_valid, out_data); end
  endtask

  task automatic test_line();
    logic [7:0] b [3] = '{8'h41, 8'h42, 8'h0D};
    for (int i = 0; i < 3; i++) cycle(1, b[i], 0, 0);
    total++; if (count !== 3) begin bad++; $display("FAIL line_count: got %0d want 3", count); end
    total++; if (lines !== 1 || line_avail !== 1'b1) begin bad++; $display("FAIL line_lines: got %0d/%b want 1/1", lines, line_avail); end
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== sb[0]) begin bad++; $display("FAIL line_pop%0d: got %h want %h", i, out_data, sb[0]); end
      cycle(0, 8'h00, 1, 0);
    end
    total++; if (count !== 0 || lines !== 0 || line_avail !== 1'b0) begin bad++; $display("FAIL line_drain: got c=%0d l=%0d want 0/0", count, lines); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1, 8'(i), 0, 0);
      if (i == DEPTH - 1) begin
        total++; if (full !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_full16: got f=%b o=%b want 1/0", full, overflow); end
      end
    end
    total++; if (overflow !== 1'b1 || count !== 16) begin bad++; $display("FAIL ovf_drop: got o=%b c=%0d want 1/16", overflow, count); end
    cycle(1, 8'h11, 0, 1);
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_set_wins: got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (out_data !== sb[0] || sb[0] !== 8'(i)) begin bad++; $display("FAIL ovf_pop%0d: got %h want %h", i, out_data, 8'(i)); end
      cycle(0, 8'h00, 1, 0);
    end
    total++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got v=%b o=%b want 0/1", out_valid, overflow); end
    cycle(0, 8'h00, 0, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'h80 + 8'(i), 0, 0);
    total++; if (out_data !== sb[0]) begin bad++; $display("FAIL pt_head: got %h want %h", out_data, sb[0]); end
    cycle(1, 8'hEE, 1, 0);
    total++; if (count !== 16 || overflow !== 1'b0) begin bad++; $display("FAIL pt_state: got c=%0d o=%b want 16/0", count, overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (out_data !== sb[0]) begin bad++; $display("FAIL pt_pop%0d: got %h want %h", i, out_data, sb[0]); end
      if (i == DEPTH - 1) begin
        total++; if (out_data !== 8'hEE) begin bad++; $display("FAIL pt_last: got %h want ee", out_data); end
      end
      cycle(0, 8'h00, 1, 0);
    end
    total++; if (count !== 0) begin bad++; $display("FAIL pt_empty: got %0d want 0", count); end
  endtask

  task automatic test_empty_simul();
    cycle(1, 8'h0D, 1, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h0D) begin bad++; $display("FAIL es_data: got v=%b d=%h want 1/0d", out_valid, out_data); end
    total++; if (lines !== 8'(m_lines()) || count !== 1) begin bad++; $display("FAIL es_lines: got l=%0d c=%0d want %0d/1", lines, count, m_lines()); end
    cycle(0, 8'h00, 1, 0);
    total++; if (lines !== 0 || out_valid !== 1'b0) begin bad++; $display("FAIL es_drain: got l=%0d v=%b want 0/0", lines, out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) cycle(1, (i % 4 == 3) ? TERM : 8'h20 + 8'(i), 0, 0);
    cycle(1, 8'h77, 0, 0);
    for (int i = 0; i < DEPTH - 5; i++) cycle(0, 8'h00, 1, 0);
    total++; if (count !== 5 || overflow !== 1'b1 || lines !== 8'(m_lines())) begin bad++; $display("FAIL rm_pre: got c=%0d o=%b l=%0d want 5/1/%0d", count, overflow, lines, m_lines()); end
    #2; reset = 1'b1; #1;
    sb.delete(); m_ovf = 1'b0;
    total++; if (count !== 0 || lines !== 0 || overflow !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rm_async: got c=%0d l=%0d o=%b v=%b want 0/0/0/0", count, lines, overflow, out_valid); end
    @(posedge clock); #1; reset = 1'b0;
    cycle(1, 8'h55, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h55 || count !== 1) begin bad++; $display("FAIL rm_first: got v=%b d=%h c=%0d want 1/55/1", out_valid, out_data, count); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_overflow();
    test_full_passthrough();
    test_empty_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
